// File: rtl/lfsr_mon_pkg.sv
// lfsr_mon_pkg: shared state encoding and period helper for the LFSR period monitor.
package lfsr_mon_pkg;

    typedef enum logic [2:0] {IDLE, ARM, COUNT, DONE, ERR} state_t;

    function automatic int max_period(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/lfsr_period_monitor.sv
// lfsr_period_monitor: measures the recurrence period of an LFSR sample stream
// and flags lock-up, stuck values and non-recurrence.
module lfsr_period_monitor
    import lfsr_mon_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 2**WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] period,
    output logic             max_len,
    output logic             err_lockup,
    output logic             err_timeout
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   ref_q, ref_d, prev_q, prev_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, period_q, period_d;
    logic               busy_q, busy_d, done_q, done_d, max_len_q, max_len_d;
    logic               err_lockup_q, err_lockup_d, err_timeout_q, err_timeout_d;
    logic [CNT_W-1:0]   cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

    always_comb begin
        state_d       = state_q;
        ref_d         = ref_q;
        prev_d        = prev_q;
        cnt_d         = cnt_q;
        period_d      = period_q;
        done_d        = done_q;
        max_len_d     = max_len_q;
        err_lockup_d  = err_lockup_q;
        err_timeout_d = err_timeout_q;
        // start wins over any sample in the same cycle, so that sample is never the reference
        if (start) begin
            state_d       = ARM;
            period_d      = '0;
            done_d        = 1'b0;
            max_len_d     = 1'b0;
            err_lockup_d  = 1'b0;
            err_timeout_d = 1'b0;
        end else begin
            case (state_q)
                ARM: begin
                    if (in_valid) begin
                        if (in_data == '0) begin
                            state_d      = ERR;
                            err_lockup_d = 1'b1;
                        end else begin
                            state_d = COUNT;
                            ref_d   = in_data;
                            prev_d  = in_data;
                            cnt_d   = '0;
                        end
                    end
                end
                COUNT: begin
                    if (in_valid) begin
                        if (in_data == '0) begin
                            state_d      = ERR;
                            err_lockup_d = 1'b1;
                        end else if (in_data == ref_q) begin
                            state_d   = DONE;
                            done_d    = 1'b1;
                            period_d  = cnt_inc;
                            max_len_d = (cnt_inc == CNT_W'(max_period(WIDTH)));
                        end else if (in_data == prev_q) begin
                            state_d      = ERR;
                            err_lockup_d = 1'b1;
                        end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                            state_d       = ERR;
                            err_timeout_d = 1'b1;
                        end else begin
                            cnt_d  = cnt_inc;
                            prev_d = in_data;
                        end
                    end
                end
                default: ;
            endcase
        end
        busy_d = (state_d == ARM) || (state_d == COUNT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            ref_q         <= '0;
            prev_q        <= '0;
            cnt_q         <= '0;
            period_q      <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            max_len_q     <= 1'b0;
            err_lockup_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ref_q         <= ref_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            period_q      <= period_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            max_len_q     <= max_len_d;
            err_lockup_q  <= err_lockup_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign period      = period_q;
    assign max_len     = max_len_q;
    assign err_lockup  = err_lockup_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: doc/lfsr_period_monitor.md
# lfsr_period_monitor

Downstream consumer of the 4-bit `lfsr` output stream. After a start command, it captures a reference sample and counts valid samples until that value recurs, then reports the sequence period. It flags all-zero lock-up, stuck states and non-recurrence. It is used in-system and in benches to confirm that a seed/tap configuration reaches maximal length, 2^WIDTH−1.

## Interface
Parameters:
- `WIDTH`, 4: LFSR state width.
- `CNT_W`, 8: period counter width; must satisfy 2^CNT_W > TIMEOUT.
- `TIMEOUT`, 2**WIDTH: number of post-reference samples allowed without recurrence before an error.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; arms or re-arms a measurement.
- `in_valid`  in  1  `in_data` is a new LFSR sample this cycle.
- `in_data`  in  WIDTH  LFSR output.
- `busy`  out  1  high in ARM and COUNT.
- `done`  out  1  measurement succeeded; held until the next `start`.
- `period`  out  CNT_W  measured period; valid while `done` is high.
- `max_len`  out  1  `done` && `period` == 2^WIDTH−1.
- `err_lockup`  out  1  zero sample or stuck sample detected; held.
- `err_timeout`  out  1  reference value did not recur within TIMEOUT samples; held.

## Operation
The design has one clock, `clk`. Reset is asynchronous and active-low on `rst_n`. All outputs are registered. Every output and all internal registers reset to 0, and the state resets to IDLE.

FSM states:
- IDLE: `busy`=0; results hold their last values.
  - `start` → ARM. Clears `done`, `period`, `max_len` and both error flags.
- ARM: `busy`=1. Waits for `in_valid`.
  - `in_data`==0 → ERR, `err_lockup`=1.
  - Otherwise: ref←`in_data`, prev←`in_data`, cnt←0 → COUNT.
- COUNT: `busy`=1. Only cycles with `in_valid` high are evaluated; gaps are ignored. Priority order on each valid sample:
  1. `in_data`==0 → ERR, `err_lockup`.
  2. `in_data`==ref → DONE, `period`←cnt+1.
  3. `in_data`==prev → ERR, `err_lockup` (stuck, non-reference value).
  4. cnt+1==TIMEOUT → ERR, `err_timeout`.
  5. Otherwise: cnt←cnt+1, prev←`in_data`.
- DONE: `done`=1, `busy`=0. `start` → ARM.
- ERR: `busy`=0. Error flag held. `start` → ARM.

Boundary conditions:
- `start` in any state, including mid-measurement, aborts the run. It clears all results and goes to ARM. A sample arriving in the same cycle as `start` is ignored; the reference is the next valid sample.
- A period of 1 is legal. A reference followed by the identical value gives `done` with `period`=1 and no error.
- cnt never wraps, because TIMEOUT < 2^CNT_W.
- `in_valid` high while in IDLE, DONE or ERR has no effect.

## Timing
- `busy` rises on the cycle after the `start` edge.
- The reference is captured on the first `in_valid` edge in ARM.
- `done`/`period`/`max_len` and the error flags assert on the cycle after the deciding sample's edge. `busy` falls on the same cycle.
- Latency from reference capture to `done` equals `period` valid samples plus one cycle, excluding valid gaps.
- `rst_n` assertion at any time forces IDLE and zero outputs immediately, with no clock required.

## Structure
- Package `lfsr_mon_pkg` contains:
  - the state enum (IDLE, ARM, COUNT, DONE, ERR);
  - a function `max_period(width)` = 2^width−1.
- The block is flat with no sub-module. The FSM and counter are in a single module.

## Test plan
- Maximal stream: reset, `start`, then drive a maximal-length 4-bit LFSR from seed 4'b1111 every cycle → `done`=1, `period`=15, `max_len`=1, no errors.
- Short cycle: `start`, then drive 3, 6, 9, 3 → `period`=3, `max_len`=0. Repeat with valid gaps of 2 cycles between samples → same result, with `done` delayed accordingly.
- Lock-up: `start`, then drive 5, 0 → `err_lockup`=1, `done`=0, `busy`=0. Separately, `start` with first sample 0 → `err_lockup` with no COUNT entry.
- Stuck and timeout:
  - `start`, then 5, 7, 7 → `err_lockup`.
  - `start`, then 5 followed by alternating 1, 2 → `err_timeout` exactly after the 16th post-reference sample.
- Restart and reset:
  - Mid-COUNT `start` together with `in_valid` → that sample is not captured; the next sample becomes the reference; prior flags are cleared.
  - `rst_n` low mid-COUNT → all outputs 0 asynchronously, and the state is IDLE.
